uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters using round-robin arbitration with bounded bursts.
- Each requester presents bytes on a valid/ready interface. The arbiter locks a grant, feeds bytes one at a time to the transmitter via a start pulse, and tracks the transmitter's busy signal.
- Sits between on-chip clients (debug console, status reporter, loopback of received bytes) and the UART TX engine that runs on the shared baud tick.

Parameters:
- NUM_REQ, 4, number of requesters (legal range 2..8).
- MAX_BURST, 4, max bytes sent per grant before forced rotation (legal range 1..255).
- BUSY_TIMEOUT, 15, cycles to wait for tx_busy to rise after tx_start before declaring a fault (legal range 1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of the requester's message.
- req_ready  out  NUM_REQ  one-hot accept strobe; byte transferred when valid&ready.
- tx_start  out  1  one-cycle pulse to the transmitter.
- tx_data  out  8  byte for the transmitter; stable from the tx_start cycle until tx_busy falls.
- tx_busy  in  1  transmitter busy (frame in progress).
- grant_valid  out  1  a requester currently holds the grant.
- grant_id  out  3  index of the granted requester.
- timeout_err  out  1  one-cycle pulse when tx_busy fails to rise within BUSY_TIMEOUT.

Behaviour:
- Reset: clk is the only clock. rst_n is sampled on the clk edge (synchronous, active-low).
  - State goes to IDLE.
  - tx_start=0, tx_data=0, grant_valid=0, grant_id=0, timeout_err=0, req_ready=0.
  - Round-robin pointer ptr=0, burst_cnt=0, last_flag=0, timer=0.
  - Reset asserted mid-transfer aborts immediately. No byte is replayed.
- Outputs are registered, except that req_ready is combinational from state, grant_id and req_valid.
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If any req_valid is set, the winner is the first index set in the order ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Next cycle: grant_id<=winner, grant_valid<=1, burst_cnt<=0, state<=SEND.
  - Otherwise remain in IDLE.
- SEND:
  - If req_valid[grant_id]=1: req_ready[grant_id]=1 this cycle. Next cycle: tx_data<=byte, tx_start<=1, last_flag<=req_last[grant_id], burst_cnt<=burst_cnt+1, timer<=0, state<=WAIT_ACK.
  - If req_valid[grant_id]=0: release the grant. ptr<=(grant_id+1) mod NUM_REQ, grant_valid<=0, state<=IDLE.
- WAIT_ACK:
  - tx_start is high only on the first cycle of this state.
  - If tx_busy=1, state<=WAIT_DONE.
  - Else timer increments. When timer reaches BUSY_TIMEOUT, pulse timeout_err for one cycle, drop the byte, and release the grant as in the SEND release case.
- WAIT_DONE:
  - Wait for tx_busy=0.
  - Then, if last_flag=1 or burst_cnt==MAX_BURST: release the grant, ptr<=(grant_id+1) mod NUM_REQ, state<=IDLE.
  - Otherwise state<=SEND and the same requester continues.
- Latency:
  - req_valid rising in IDLE at cycle 0 gives grant at cycle 1, req_ready at cycle 1, and tx_start at cycle 2.
  - Minimum gap between consecutive tx_start pulses from the same requester is frame time + 2 cycles.
- Boundary conditions:
  - tx_start is never issued while tx_busy=1.
  - A requester dropping req_valid mid-message loses its grant. That is legal and is not an error.
  - req_valid of non-granted requesters is ignored while a grant is held.
  - ptr advances only on release. After release, the releasing requester becomes lowest priority.
  - A single active requester with a long message is re-granted after each burst, with one IDLE cycle between bursts.
  - burst_cnt is wide enough to hold MAX_BURST with no wrap.
  - req_last is used only together with an accepted byte.

Test Plan:
- req_valid=0001, data 0x55, last=1, model tx_busy high for 10 cycles starting 1 cycle after tx_start → exactly one req_ready, tx_start at cycle 2 with tx_data=0x55, grant_valid back to 0 after busy falls, ptr=1.
- req_valid=1111 held, each message 1 byte with last=1 → grant order 0,1,2,3,0 and tx_data shows each requester's byte in that order.
- Requester 2 sends 10 bytes 0x10..0x19 with last on the final byte, MAX_BURST=4, requester 0 also valid → bytes 0x10–0x13, then requester 0's byte, then 0x14–0x17, then requester 0 again.
- tx_busy held 0 after tx_start → timeout_err pulses once at cycle BUSY_TIMEOUT after tx_start, grant released, no second tx_start for that byte.
- Requester 1 drops req_valid after 2 of 3 bytes while requester 3 is waiting → grant passes to 3 after the second frame, no timeout_err.
- rst_n=0 for 1 cycle during WAIT_DONE → next cycle all outputs at reset values, ptr=0, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A grant is held for at most MAX_BURST bytes or until the message ends, then the
// pointer rotates past the releasing requester so it becomes lowest priority.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [2:0]           grant_id,
  output logic                 timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {StIdle, StSend, StWaitAck, StWaitDone} state_e;

  state_e        state_q;
  logic [IW-1:0] gid_q;
  logic [IW-1:0] ptr_q;
  logic [7:0]    burst_cnt_q;
  logic [7:0]    timer_q;
  logic          last_flag_q;

  logic          win_found;
  logic [IW-1:0] win_id;
  logic [CW-1:0] cand;
  logic [IW-1:0] gid_next;
  logic [7:0]    sel_byte;

  assign grant_id = 3'(gid_q);
  assign sel_byte = req_data[{gid_q, 3'b000} +: 8];
  // Pointer value after release: the requester just served goes to the back of the line.
  assign gid_next = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + IW'(1);

  // Scan requesters starting at ptr, wrapping modulo NUM_REQ; first valid one wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IW-1:0];
      end
    end
  end

  // Accept strobe goes only to the granted requester, only while offering a byte.
  always_comb begin
    req_ready = '0;
    if (state_q == StSend) begin
      req_ready[gid_q] = req_valid[gid_q];
    end
  end

  // Arbitration FSM with registered transmitter and grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_valid <= 1'b0;
      gid_q       <= '0;
      timeout_err <= 1'b0;
      ptr_q       <= '0;
      burst_cnt_q <= 8'd0;
      last_flag_q <= 1'b0;
      timer_q     <= 8'd0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_found) begin
            gid_q       <= win_id;
            grant_valid <= 1'b1;
            burst_cnt_q <= 8'd0;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (req_valid[gid_q]) begin
            tx_data     <= sel_byte;
            tx_start    <= 1'b1;
            last_flag_q <= req_last[gid_q];
            burst_cnt_q <= burst_cnt_q + 8'd1;
            timer_q     <= 8'd0;
            state_q     <= StWaitAck;
          end else begin
            // Requester went quiet mid-message: give up the grant.
            ptr_q       <= gid_next;
            grant_valid <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StWaitAck: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end else if (timer_q == 8'(BUSY_TIMEOUT - 1)) begin
            // Timer would reach BUSY_TIMEOUT this edge: the byte is dropped.
            timeout_err <= 1'b1;
            ptr_q       <= gid_next;
            grant_valid <= 1'b0;
            state_q     <= StIdle;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            if (last_flag_q || (burst_cnt_q == 8'(MAX_BURST))) begin
              ptr_q       <= gid_next;
              grant_valid <= 1'b0;
              state_q     <= StIdle;
            end else begin
              state_q <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester sources and a transmitter responder are driven
// from queues; a transaction-level reference model predicts every output each cycle.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           grant_valid;
  logic [2:0]     grant_id;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .MAX_BURST   (MB),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- sources and transmitter responder ----------------
  logic [8:0] mem [N][256];
  int  head [N];
  int  tail [N];
  bit  en   [N];
  bit  hs   [N];
  int  acc  [N];
  bit  rand_mode = 0;
  bit  ack_en    = 1;
  int  frame_len = 10;
  int  busy_left = 0;
  bit  saw_start = 0;

  int st_cyc[$];
  int st_id[$];
  int st_data[$];
  int to_cyc[$];

  function automatic int at(input int q[$], input int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  task automatic push(input int i, input logic [7:0] b, input bit last);
    mem[i][tail[i] & 255] = {last, b};
    tail[i]++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = en[i] && (head[i] != tail[i]);
      req_data[8*i +: 8] = req_valid[i] ? mem[i][head[i] & 255][7:0] : 8'h00;
      req_last[i]       = req_valid[i] ? mem[i][head[i] & 255][8] : 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        head[i]++;
        acc[i]++;
      end
    end
    if (busy_left > 0) busy_left--;
    if (saw_start && ack_en) busy_left = rand_mode ? int'($urandom_range(1, 6)) : frame_len;
    if (!rst_n) busy_left = 0;
    tx_busy = (busy_left > 0);
    if (rand_mode) begin
      ack_en = ($urandom_range(0, 19) != 0);
      rst_n  = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < N; i++) begin
        en[i] = ($urandom_range(0, 99) < 85);
        if (head[i] == tail[i] && $urandom_range(0, 9) == 0) begin
          int len;
          len = int'($urandom_range(1, 6));
          for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
        end
      end
    end
    drive_reqs();
  endtask

  task automatic clear_logs();
    st_cyc.delete();
    st_id.delete();
    st_data.delete();
    to_cyc.delete();
    for (int i = 0; i < N; i++) acc[i] = 0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ack_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i]   = 1'b1;
      head[i] = 0;
      tail[i] = 0;
    end
    drive_reqs();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // holder: requester owning the line (-1 none); inflight: a byte was launched and its
  // frame is not finished; online: the transmitter acknowledged it by going busy.
  int         m_holder   = -1;
  int         m_ptr      = 0;
  int         m_sent     = 0;
  int         m_age      = 0;
  bit         m_inflight = 0;
  bit         m_online   = 0;
  bit         m_final    = 0;
  bit         e_start    = 0;
  bit         e_terr     = 0;
  logic [7:0] e_data     = 8'h00;
  logic [2:0] e_gid      = 3'd0;

  task automatic model_release();
    m_ptr      = (m_holder + 1) % N;
    m_holder   = -1;
    m_inflight = 0;
    m_online   = 0;
  endtask

  task automatic model_edge();
    e_start = 0;
    e_terr  = 0;
    if (!rst_n) begin
      m_holder = -1; m_ptr = 0; m_sent = 0; m_age = 0;
      m_inflight = 0; m_online = 0; m_final = 0;
      e_data = 8'h00; e_gid = 3'd0;
    end else if (m_holder < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req_valid[c]) begin
          m_holder = c;
          m_sent   = 0;
          e_gid    = 3'(c);
          break;
        end
      end
    end else if (!m_inflight) begin
      if (req_valid[m_holder]) begin
        e_data     = req_data[8*m_holder +: 8];
        e_start    = 1;
        m_final    = req_last[m_holder];
        m_sent     = m_sent + 1;
        m_age      = 0;
        m_inflight = 1;
      end else begin
        model_release();
      end
    end else if (!m_online) begin
      if (tx_busy) m_online = 1;
      else if (m_age + 1 == TO) begin
        e_terr = 1;
        model_release();
      end else m_age = m_age + 1;
    end else if (!tx_busy) begin
      m_inflight = 0;
      m_online   = 0;
      if (m_final || m_sent == MB) model_release();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Compare process: outputs are settled mid-cycle.
  initial begin
    forever begin
      logic [N-1:0] e_ready;
      @(negedge clk);
      for (int i = 0; i < N; i++) hs[i] = req_valid[i] & req_ready[i] & rst_n;
      saw_start = tx_start;
      if (tx_start === 1'b1) begin
        st_cyc.push_back(cyc);
        st_id.push_back(int'(grant_id));
        st_data.push_back(int'(tx_data));
      end
      if (timeout_err === 1'b1) to_cyc.push_back(cyc);
      if (chk_en) begin
        e_ready = '0;
        if (m_holder >= 0 && !m_inflight && req_valid[m_holder]) e_ready[m_holder] = 1'b1;
        check("tx_start", 32'(tx_start), 32'(e_start));
        check("tx_data", 32'(tx_data), 32'(e_data));
        check("grant_valid", 32'(grant_valid), 32'(m_holder >= 0));
        check("grant_id", 32'(grant_id), 32'(e_gid));
        check("timeout_err", 32'(timeout_err), 32'(e_terr));
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("start_while_busy", 32'(tx_start & tx_busy), 32'd0);
      end
    end
  end

  // ---------------- directed and random stimulus ----------------
  initial begin
    int c0;
    int exp_id [5];
    int exp_dt [5];
    int b3 [12];
    bit dropped;

    tx_busy = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0; tail[i] = 0; en[i] = 1'b1; acc[i] = 0; hs[i] = 1'b0;
    end
    drive_reqs();
    step();
    chk_en = 1;
    step();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Single byte from requester 0.
    clear_logs();
    push(0, 8'h55, 1'b1);
    drive_reqs();
    c0 = cyc;
    repeat (25) step();
    check("t1_starts", st_cyc.size(), 1);
    check("t1_start_cyc", at(st_cyc, 0), c0 + 2);
    check("t1_data", at(st_data, 0), 32'h55);
    check("t1_accepts", acc[0], 1);
    check("t1_released", 32'(grant_valid), 32'd0);
    // ptr now 1: requester 1 beats requester 0, then wraps to 0.
    clear_logs();
    push(0, 8'h60, 1'b1);
    push(1, 8'h61, 1'b1);
    drive_reqs();
    repeat (40) step();
    check("t1_ptr_first", at(st_id, 0), 1);
    check("t1_ptr_second", at(st_id, 1), 0);

    // All four valid, one-byte messages: round robin 0,1,2,3,0.
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) push(i, 8'(8'h40 + i), 1'b1);
    push(0, 8'h50, 1'b1);
    drive_reqs();
    repeat (100) step();
    exp_id = '{0, 1, 2, 3, 0};
    exp_dt = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h50};
    for (int k = 0; k < 5; k++) begin
      check("t2_order_id", at(st_id, k), exp_id[k]);
      check("t2_order_data", at(st_data, k), exp_dt[k]);
    end

    // Burst limit: requester 2 long message interleaved with requester 0.
    do_reset();
    clear_logs();
    for (int b = 0; b < 10; b++) push(2, 8'(8'h10 + b), b == 9);
    drive_reqs();
    step();
    push(0, 8'hE0, 1'b1);
    push(0, 8'hE1, 1'b1);
    drive_reqs();
    repeat (220) step();
    b3 = '{32'h10, 32'h11, 32'h12, 32'h13, 32'hE0, 32'h14, 32'h15, 32'h16, 32'h17, 32'hE1,
           32'h18, 32'h19};
    for (int k = 0; k < 12; k++) check("t3_burst_data", at(st_data, k), b3[k]);

    // Transmitter never acknowledges.
    do_reset();
    clear_logs();
    ack_en = 1'b0;
    push(3, 8'h77, 1'b1);
    drive_reqs();
    c0 = cyc;
    repeat (40) step();
    check("t4_starts", st_cyc.size(), 1);
    check("t4_timeouts", to_cyc.size(), 1);
    check("t4_timeout_cyc", at(to_cyc, 0), c0 + 2 + TO);
    check("t4_released", 32'(grant_valid), 32'd0);
    ack_en = 1'b1;
    clear_logs();
    push(2, 8'hB2, 1'b1);
    push(0, 8'hB0, 1'b1);
    drive_reqs();
    repeat (40) step();
    check("t4_ptr_wrap", at(st_id, 0), 0);

    // Requester 1 drops valid after two bytes, requester 3 waiting.
    do_reset();
    clear_logs();
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b0);
    push(1, 8'h33, 1'b1);
    drive_reqs();
    step();
    push(3, 8'h3F, 1'b1);
    drive_reqs();
    dropped = 0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (!dropped && acc[1] == 2) begin
        en[1]   = 1'b0;
        dropped = 1;
        drive_reqs();
      end
    end
    en[1] = 1'b1;
    drive_reqs();
    repeat (40) step();
    exp_id = '{1, 1, 3, 1, -1};
    exp_dt = '{32'h31, 32'h32, 32'h3F, 32'h33, -1};
    for (int k = 0; k < 4; k++) begin
      check("t5_id", at(st_id, k), exp_id[k]);
      check("t5_data", at(st_data, k), exp_dt[k]);
    end
    check("t5_no_timeout", to_cyc.size(), 0);

    // Reset while the frame is on the line.
    do_reset();
    clear_logs();
    push(2, 8'h99, 1'b1);
    drive_reqs();
    repeat (5) step();
    check("t6_pre_grant", 32'(grant_valid), 32'd1);
    check("t6_pre_data", 32'(tx_data), 32'h99);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_tx_start", 32'(tx_start), 32'd0);
    check("t6_tx_data", 32'(tx_data), 32'd0);
    check("t6_grant_valid", 32'(grant_valid), 32'd0);
    check("t6_grant_id", 32'(grant_id), 32'd0);
    check("t6_timeout_err", 32'(timeout_err), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd0);
    clear_logs();
    push(3, 8'hA3, 1'b1);
    push(0, 8'hA0, 1'b1);
    drive_reqs();
    c0 = cyc;
    repeat (40) step();
    check("t6_restart_id", at(st_id, 0), 0);
    check("t6_restart_cyc", at(st_cyc, 0), c0 + 2);
    check("t6_second_id", at(st_id, 1), 3);

    // Randomized traffic, drops, missing acks and resets.
    do_reset();
    clear_logs();
    rand_mode = 1;
    repeat (4000) step();
    rand_mode = 0;
    rst_n     = 1'b1;
    ack_en    = 1'b1;
    for (int i = 0; i < N; i++) en[i] = 1'b1;
    drive_reqs();
    repeat (200) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
